// File: rtl/rfnoc_lms_cfilter_core.sv
// rtl/rfnoc_lms_cfilter_core.sv - serial complex LMS adaptive FIR core (one complex MAC per cycle)
module rfnoc_lms_cfilter_core #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 18,
    parameter int NUM_TAPS = 8,
    parameter int MU_W     = 16,
    parameter int ACC_W    = 40
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [2*DATA_W-1:0]         main_in_tdata,
    input  logic                        main_in_tvalid,
    output logic                        main_in_tready,
    input  logic                        main_in_tlast,
    input  logic [2*DATA_W-1:0]         aux_in_tdata,
    input  logic                        aux_in_tvalid,
    output logic                        aux_in_tready,
    input  logic                        aux_in_tlast,
    output logic [2*DATA_W-1:0]         out_tdata,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic                        out_tlast,
    input  logic [MU_W-1:0]             mu,
    input  logic                        adapt_en,
    input  logic                        out_sel,
    input  logic                        coef_clear,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_rd_idx,
    output logic [2*COEF_W-1:0]         coef_rd_data,
    output logic                        busy
);
    localparam int IDX_W  = $clog2(NUM_TAPS);
    localparam int PROD_W = COEF_W + DATA_W;
    localparam int UPD_W  = MU_W + 2*DATA_W + 2;
    localparam int SHIFT  = MU_W - 1 + 2*DATA_W - COEF_W - 1;

    localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] DMIN = ~DMAX;
    localparam logic signed [UPD_W-1:0] CMAX = {{(UPD_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [UPD_W-1:0] CMIN = ~CMAX;

    typedef enum logic [2:0] {S_IDLE, S_FILTER, S_ERR, S_UPDATE, S_DRAIN} state_t;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        if (v > DMAX)      return DMAX[DATA_W-1:0];
        else if (v < DMIN) return DMIN[DATA_W-1:0];
        else               return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [UPD_W-1:0] v);
        if (v > CMAX)      return CMAX[COEF_W-1:0];
        else if (v < CMIN) return CMIN[COEF_W-1:0];
        else               return v[COEF_W-1:0];
    endfunction

    state_t                    state, state_n;
    logic [IDX_W-1:0]          k;
    logic                      last_tap, accept, clear_now, clear_pending;
    logic signed [COEF_W-1:0]  w_i [NUM_TAPS];
    logic signed [COEF_W-1:0]  w_q [NUM_TAPS];
    logic signed [DATA_W-1:0]  x_i [NUM_TAPS];
    logic signed [DATA_W-1:0]  x_q [NUM_TAPS];
    logic signed [DATA_W-1:0]  d_i, d_q, e_i, e_q;
    logic signed [ACC_W-1:0]   acc_i, acc_q, acc_nxt_i, acc_nxt_q;
    logic signed [MU_W-1:0]    mu_c;
    logic                      adapt_c, sel_c, tlast_c;
    logic signed [COEF_W-1:0]  wk_i, wk_q, wn_i, wn_q;
    logic signed [DATA_W-1:0]  xk_i, xk_q, y_i, y_q, ee_i, ee_q;
    logic signed [PROD_W-1:0]  p_ii, p_qq, p_iq, p_qi;
    logic signed [UPD_W-1:0]   c_re, c_im, u_re, u_im;
    logic [2*COEF_W-1:0]       rd_word;
    logic                      unused_aux_tlast;

    assign unused_aux_tlast = aux_in_tlast;
    assign clear_now        = clear_pending || coef_clear;
    assign main_in_tready   = (state == S_IDLE) && !clear_now;
    assign aux_in_tready    = main_in_tready;
    assign accept           = main_in_tready && main_in_tvalid && aux_in_tvalid;
    assign busy             = (state != S_IDLE);
    assign last_tap         = (k == IDX_W'(NUM_TAPS-1));

    // Datapath arithmetic for the tap currently addressed by k: MAC, output/error, weight step
    always_comb begin
        wk_i      = w_i[k];
        wk_q      = w_q[k];
        xk_i      = x_i[k];
        xk_q      = x_q[k];
        p_ii      = PROD_W'(wk_i) * PROD_W'(xk_i);
        p_qq      = PROD_W'(wk_q) * PROD_W'(xk_q);
        p_iq      = PROD_W'(wk_i) * PROD_W'(xk_q);
        p_qi      = PROD_W'(wk_q) * PROD_W'(xk_i);
        acc_nxt_i = acc_i + ACC_W'(p_ii) - ACC_W'(p_qq);
        acc_nxt_q = acc_q + ACC_W'(p_iq) + ACC_W'(p_qi);
        y_i       = sat_data(acc_i >>> (COEF_W-1));
        y_q       = sat_data(acc_q >>> (COEF_W-1));
        ee_i      = sat_data(ACC_W'(d_i) - ACC_W'(y_i));
        ee_q      = sat_data(ACC_W'(d_q) - ACC_W'(y_q));
        // e * conj(x_k), scaled by mu; e_i/e_q hold the error latched in ERR
        c_re      = UPD_W'(e_i) * UPD_W'(xk_i) + UPD_W'(e_q) * UPD_W'(xk_q);
        c_im      = UPD_W'(e_q) * UPD_W'(xk_i) - UPD_W'(e_i) * UPD_W'(xk_q);
        u_re      = c_re * UPD_W'(mu_c);
        u_im      = c_im * UPD_W'(mu_c);
        wn_i      = sat_coef(UPD_W'(wk_i) + (u_re >>> SHIFT));
        wn_q      = sat_coef(UPD_W'(wk_q) + (u_im >>> SHIFT));
        rd_word   = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            if (coef_rd_idx == IDX_W'(t)) rd_word = {w_i[t], w_q[t]};
        end
    end

    // Next-state sequencing: accept -> FILTER -> ERR -> (UPDATE) -> DRAIN -> IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (accept) state_n = S_FILTER;
            S_FILTER: if (last_tap) state_n = S_ERR;
            S_ERR:    state_n = adapt_c ? S_UPDATE : S_DRAIN;
            S_UPDATE: if (last_tap) state_n = S_DRAIN;
            S_DRAIN:  if (!out_tvalid || out_tready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_n;
    end

    // Sample capture, accumulation, output register, weight update and clear handling
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                w_i[t] <= '0;
                w_q[t] <= '0;
                x_i[t] <= '0;
                x_q[t] <= '0;
            end
            d_i <= '0; d_q <= '0; e_i <= '0; e_q <= '0;
            acc_i <= '0; acc_q <= '0; mu_c <= '0; k <= '0;
            adapt_c <= 1'b0; sel_c <= 1'b0; tlast_c <= 1'b0; clear_pending <= 1'b0;
            out_tdata <= '0; out_tvalid <= 1'b0; out_tlast <= 1'b0;
        end else begin
            if (out_tvalid && out_tready) out_tvalid <= 1'b0;
            if (state == S_IDLE) begin
                if (clear_now) begin
                    for (int t = 0; t < NUM_TAPS; t++) begin
                        w_i[t] <= '0;
                        w_q[t] <= '0;
                        x_i[t] <= '0;
                        x_q[t] <= '0;
                    end
                    clear_pending <= 1'b0;
                end
            end else if (coef_clear) begin
                clear_pending <= 1'b1;
            end
            if (accept) begin
                for (int t = NUM_TAPS-1; t > 0; t--) begin
                    x_i[t] <= x_i[t-1];
                    x_q[t] <= x_q[t-1];
                end
                x_i[0]  <= main_in_tdata[2*DATA_W-1:DATA_W];
                x_q[0]  <= main_in_tdata[DATA_W-1:0];
                d_i     <= aux_in_tdata[2*DATA_W-1:DATA_W];
                d_q     <= aux_in_tdata[DATA_W-1:0];
                tlast_c <= main_in_tlast;
                mu_c    <= mu;
                adapt_c <= adapt_en;
                sel_c   <= out_sel;
                acc_i   <= '0;
                acc_q   <= '0;
            end
            if (state == S_FILTER || state == S_UPDATE) k <= last_tap ? '0 : k + 1'b1;
            else                                        k <= '0;
            if (state == S_FILTER) begin
                acc_i <= acc_nxt_i;
                acc_q <= acc_nxt_q;
            end
            if (state == S_ERR) begin
                e_i        <= ee_i;
                e_q        <= ee_q;
                out_tdata  <= sel_c ? {y_i, y_q} : {ee_i, ee_q};
                out_tvalid <= 1'b1;
                out_tlast  <= tlast_c;
            end
            if (state == S_UPDATE) begin
                w_i[k] <= wn_i;
                w_q[k] <= wn_q;
            end
        end
    end

    // Registered coefficient readback
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) coef_rd_data <= '0;
        else           coef_rd_data <= rd_word;
    end
endmodule
